explored_set_engine: RTL

- Parametrised successor to the explored-list child/parent scanners in the A* pathfinding datapath.
- Owns the explored-node RAM port and tracks its own fill count. Scans stop at the fill count instead of at a zero-id sentinel, so id 0 is a legal key.
- Performs one operation at a time through a valid/ready handshake: LOOKUP, INSERT, INSERT_UNIQUE, CLEAR.
- Returns hit flag, hit address and the full matched record.

---
 rtl/explored_set_engine.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/explored_set_engine.sv
// Explored-set engine: owns the explored-node RAM port and its fill count and
// runs one LOOKUP / INSERT / INSERT_UNIQUE / CLEAR at a time.
// Latency: LOOKUP hit at k = 1+(k+1)(RD_LAT+1), miss = 1+N(RD_LAT+1),
//          INSERT_UNIQUE miss +1, INSERT 2, CLEAR 1 (accept edge to result_valid).
// Backpressure: op_ready is high only in IDLE; inputs are ignored while busy.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   op_*               request handshake, opcode, search key and record to write
//   mem_rd_* / mem_wr_* explored RAM read (RD_LAT-cycle) and write ports
//   result_valid, hit, hit_addr, hit_record, inserted, overflow  per-op result
//   fill_count, full   occupancy of the explored set
module explored_set_engine #(
  parameter int MAX_NODES = 100,
  parameter int ADDR_W    = 7,
  parameter int REC_W     = 272,
  parameter int ID_W      = 16,
  parameter int KEY_LSB   = 224,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ID_W-1:0]   op_key,
  input  logic [REC_W-1:0]  op_record,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [REC_W-1:0]  mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [REC_W-1:0]  mem_wr_data,
  output logic              result_valid,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr,
  output logic [REC_W-1:0]  hit_record,
  output logic              inserted,
  output logic              overflow,
  output logic [ADDR_W:0]   fill_count,
  output logic              full
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_IUNIQ  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_NODES);
  // WAIT runs RD_LAT-1 cycles; the counter counts down to zero.
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_PROBE, S_WAIT, S_COMPARE, S_WRITE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          code_q, code_d;
  logic [ID_W-1:0]     key_q, key_d;
  logic [REC_W-1:0]    rec_q, rec_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic                rv_q, rv_d;
  logic                hit_q, hit_d;
  logic [ADDR_W-1:0]   hit_addr_q, hit_addr_d;
  logic [REC_W-1:0]    hit_rec_q, hit_rec_d;
  logic                ins_q, ins_d;
  logic                ovf_q, ovf_d;
  logic                rdy_q, rdy_d;
  logic                match;
  logic                full_now;

  assign match    = (mem_rd_data[KEY_LSB +: ID_W] == key_q);
  assign full_now = (fill_q == MAX_CNT);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    key_d      = key_q;
    rec_d      = rec_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    fill_d     = fill_q;
    rd_addr_d  = rd_addr_q;
    hit_d      = hit_q;
    hit_addr_d = hit_addr_q;
    hit_rec_d  = hit_rec_q;
    ins_d      = ins_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          code_d     = op_code;
          key_d      = op_key;
          rec_d      = op_record;
          idx_d      = '0;
          hit_d      = 1'b0;
          hit_addr_d = '0;
          hit_rec_d  = '0;
          ins_d      = 1'b0;
          ovf_d      = 1'b0;
          case (op_code)
            OP_LOOKUP, OP_IUNIQ: begin
              if (fill_q != '0) begin
                state_d   = S_PROBE;
                rd_addr_d = '0;
              end else begin
                // Empty set: a unique insert cannot collide, go straight to the write.
                state_d = (op_code == OP_IUNIQ) ? S_WRITE : S_RESP;
              end
            end
            OP_INSERT: state_d = S_WRITE;
            OP_CLEAR: begin
              fill_d  = '0;
              state_d = S_RESP;
            end
            default: state_d = S_RESP;
          endcase
        end
      end
      S_PROBE: begin
        if (RD_LAT == 1) begin
          state_d = S_COMPARE;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_COMPARE;
        else              wcnt_d  = wcnt_q - 3'd1;
      end
      S_COMPARE: begin
        if (match) begin
          hit_d      = 1'b1;
          hit_addr_d = idx_q;
          hit_rec_d  = mem_rd_data;
          state_d    = S_RESP;
        end else if (({1'b0, idx_q} + (ADDR_W+1)'(1)) < fill_q) begin
          // Scan is bounded by fill_count, so the index never reaches it.
          idx_d     = idx_q + ADDR_W'(1);
          rd_addr_d = idx_q + ADDR_W'(1);
          state_d   = S_PROBE;
        end else begin
          state_d = (code_q == OP_IUNIQ) ? S_WRITE : S_RESP;
        end
      end
      S_WRITE: begin
        if (!full_now) begin
          fill_d = fill_q + (ADDR_W+1)'(1);
          ins_d  = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Write strobe is registered so it lines up with the WRITE cycle; fill
    // cannot change between the decision and the WRITE cycle.
    wr_en_d = (state_d == S_WRITE) && (state_q != S_WRITE) && !full_now;
    rv_d    = (state_d == S_RESP);
    rdy_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      key_q      <= '0;
      rec_q      <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      fill_q     <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      rv_q       <= 1'b0;
      hit_q      <= 1'b0;
      hit_addr_q <= '0;
      hit_rec_q  <= '0;
      ins_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      key_q      <= key_d;
      rec_q      <= rec_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      fill_q     <= fill_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      rv_q       <= rv_d;
      hit_q      <= hit_d;
      hit_addr_q <= hit_addr_d;
      hit_rec_q  <= hit_rec_d;
      ins_q      <= ins_d;
      ovf_q      <= ovf_d;
      rdy_q      <= rdy_d;
    end
  end

  // A reset arriving in the WRITE cycle must suppress that cycle's strobe.
  assign mem_wr_en    = wr_en_q & ~reset;
  assign mem_wr_addr  = fill_q[ADDR_W-1:0];
  assign mem_wr_data  = rec_q;
  assign mem_rd_addr  = rd_addr_q;
  assign op_ready     = rdy_q;
  assign result_valid = rv_q;
  assign hit          = hit_q;
  assign hit_addr     = hit_addr_q;
  assign hit_record   = hit_rec_q;
  assign inserted     = ins_q;
  assign overflow     = ovf_q;
  assign fill_count   = fill_q;
  assign full         = full_now;

endmodule
